// File: rtl/spi_bus_arb_pkg.sv
// Shared types and constants for the two-requester SPI monarch arbiter.
package spi_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam logic OWN_INERT = 1'b0;
  localparam logic OWN_A2D   = 1'b1;

  localparam int CMD_W = 16;

endpackage

// File: rtl/spi_bus_arb_if.sv
// Bus bundle between the requesters, the SPI monarch and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface spi_bus_arb_if;
  import spi_bus_arb_pkg::*;

  // requester side
  logic             req0;
  logic             req1;
  logic [CMD_W-1:0] cmd0;
  logic [CMD_W-1:0] cmd1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [CMD_W-1:0] rd_data0;
  logic [CMD_W-1:0] rd_data1;

  // monarch side
  logic             m_wrt;
  logic [CMD_W-1:0] m_cmd;
  logic             m_done;
  logic [CMD_W-1:0] m_rd_data;
  logic             m_SS_n;

  // device chip selects
  logic             SS0_n;
  logic             SS1_n;

  modport slave (
    input  req0, req1, cmd0, cmd1, m_done, m_rd_data, m_SS_n,
    output gnt0, gnt1, done0, done1, rd_data0, rd_data1, m_wrt, m_cmd, SS0_n, SS1_n
  );

  modport master (
    output req0, req1, cmd0, cmd1, m_done, m_rd_data, m_SS_n,
    input  gnt0, gnt1, done0, done1, rd_data0, rd_data1, m_wrt, m_cmd, SS0_n, SS1_n
  );

endinterface

// File: rtl/spi_bus_arb.sv
// Round-robin arbiter sharing one SPI monarch between the inertial sensor
// interface (owner 0) and the A2D interface (owner 1), with an idle gap
// enforced after each completed transaction.
module spi_bus_arb #(
  parameter int GAP = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_bus_arb_if.slave bus
);
  import spi_bus_arb_pkg::*;

  // The parameter GAP shadows the enum literal of the same name, so the
  // gap state is referenced through the package explicitly.
  localparam arb_state_t ST_GAP   = spi_bus_arb_pkg::GAP;
  localparam logic [7:0] GAP_LOAD = 8'(GAP);

  arb_state_t       state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_reg, last_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             wrt_reg, wrt_next;
  logic             gnt0_reg, gnt0_next;
  logic             gnt1_reg, gnt1_next;
  logic [CMD_W-1:0] cmd_reg, cmd_next;
  logic             pick;
  logic             xfer0;
  logic             xfer1;

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not last.
  always_comb begin
    pick = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;
  end

  // State register and registered launch outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_INERT;
      last_reg  <= OWN_A2D;
      cnt_reg   <= 8'd0;
      wrt_reg   <= 1'b0;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      cmd_reg   <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
      wrt_reg   <= wrt_next;
      gnt0_reg  <= gnt0_next;
      gnt1_reg  <= gnt1_next;
      cmd_reg   <= cmd_next;
    end
  end

  // Next-state logic: launch from IDLE, wait for done in XFER, count down in GAP.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    wrt_next   = 1'b0;
    gnt0_next  = 1'b0;
    gnt1_next  = 1'b0;
    cmd_next   = cmd_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_next = pick;
          last_next  = pick;
          cmd_next   = (pick == OWN_A2D) ? bus.cmd1 : bus.cmd0;
          wrt_next   = 1'b1;
          gnt0_next  = (pick == OWN_INERT);
          gnt1_next  = (pick == OWN_A2D);
          state_next = XFER;
        end
      end
      XFER: begin
        // The owner is frozen here; requests are not looked at.
        if (bus.m_done) begin
          if (GAP == 0) begin
            state_next = IDLE;
          end else begin
            cnt_next   = GAP_LOAD;
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg <= 8'd1) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Done routing and chip-select demux depend only on state/owner registers
  // plus the live monarch signals, so they follow with zero delay.
  always_comb begin
    xfer0 = (state_reg == XFER) && (owner_reg == OWN_INERT);
    xfer1 = (state_reg == XFER) && (owner_reg == OWN_A2D);
  end

  assign bus.done0    = xfer0 && bus.m_done;
  assign bus.done1    = xfer1 && bus.m_done;
  assign bus.SS0_n    = xfer0 ? bus.m_SS_n : 1'b1;
  assign bus.SS1_n    = xfer1 ? bus.m_SS_n : 1'b1;
  assign bus.rd_data0 = bus.m_rd_data;
  assign bus.rd_data1 = bus.m_rd_data;
  assign bus.m_wrt    = wrt_reg;
  assign bus.m_cmd    = cmd_reg;
  assign bus.gnt0     = gnt0_reg;
  assign bus.gnt1     = gnt1_reg;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Self-checking bench for spi_bus_arb: a cycle-by-cycle vector table for the
// basic flow, hand-written sequences for reset and contention, and a grant
// scoreboard that checks every gnt against the expected owner and command.
module tb_spi_bus_arb;

  localparam int TB_GAP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  spi_bus_arb_if bus ();

  spi_bus_arb #(.GAP(TB_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        req0;
    logic        req1;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    logic        m_done;
    logic        m_ss_n;
    logic [15:0] rd;
    logic        gnt0;
    logic        gnt1;
    logic        wrt;
    logic [15:0] cmd;
    logic        done0;
    logic        done1;
    logic        ss0_n;
    logic        ss1_n;
  } vec_t;

  typedef struct {
    logic        owner;
    logic [15:0] cmd;
  } gnt_exp_t;

  gnt_exp_t sb_q[$];
  vec_t     tv[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every grant must match the next queued expectation.
  always @(negedge clk) begin
    gnt_exp_t e;
    if (!rst && (bus.gnt0 || bus.gnt1)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_gnt: got gnt0=%0b gnt1=%0b expected none at cycle %0d",
                 bus.gnt0, bus.gnt1, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_onehot", 32'(bus.gnt0 ^ bus.gnt1), 32'd1);
        chk("sb_owner", 32'(bus.gnt1), 32'(e.owner));
        chk("sb_cmd", 32'(bus.m_cmd), 32'(e.cmd));
        chk("sb_wrt", 32'(bus.m_wrt), 32'd1);
        $display("grant owner=%0d cmd=%04h cycle=%0d", bus.gnt1, bus.m_cmd, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cyc_done;
    int  cyc_wrt;
    bit  got;
    logic own;

    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.cmd0 = 16'h1234;
    bus.cmd1 = 16'h5678;
    bus.m_done = 1'b1;
    bus.m_rd_data = 16'h0000;
    bus.m_SS_n = 1'b0;

    // Reset state, with inputs that would otherwise provoke every output.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wrt", 32'(bus.m_wrt), 32'd0);
    chk("rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd0);
    chk("rst_done", 32'({bus.done0, bus.done1}), 32'd0);
    chk("rst_cmd", 32'(bus.m_cmd), 32'h0000);
    chk("rst_ss", 32'({bus.SS0_n, bus.SS1_n}), 32'b11);
    $display("reset state checked");

    tick();
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.m_done = 1'b0;
    bus.m_SS_n = 1'b1;

    // req0 req1 cmd0 cmd1 m_done m_ss_n rd | gnt0 gnt1 wrt cmd done0 done1 ss0 ss1
    tv[0]  = '{0,0,16'hA201,16'hB301,1,0,16'h1111, 0,0,0,16'h0000,0,0,1,1};
    tv[1]  = '{1,1,16'hA201,16'hB301,0,0,16'h1111, 0,0,0,16'h0000,0,0,1,1};
    tv[2]  = '{1,1,16'hA201,16'hB301,0,0,16'h1111, 1,0,1,16'hA201,0,0,0,1};
    tv[3]  = '{0,1,16'hA201,16'hB301,0,1,16'h1111, 0,0,0,16'hA201,0,0,1,1};
    tv[4]  = '{0,0,16'hA201,16'hB301,1,0,16'h00C5, 0,0,0,16'hA201,1,0,0,1};
    tv[5]  = '{0,0,16'hA201,16'hB301,1,0,16'h00C5, 0,0,0,16'hA201,0,0,1,1};
    tv[6]  = '{0,1,16'hA201,16'hB301,0,0,16'h00C5, 0,0,0,16'hA201,0,0,1,1};
    tv[7]  = '{0,1,16'hA201,16'hB301,0,0,16'h00C5, 0,0,0,16'hA201,0,0,1,1};
    tv[8]  = '{0,1,16'hA201,16'hB301,0,0,16'h00C5, 0,0,0,16'hA201,0,0,1,1};
    tv[9]  = '{0,1,16'hA201,16'hB301,0,0,16'h00C5, 0,0,0,16'hA201,0,0,1,1};
    tv[10] = '{0,1,16'hA201,16'hB301,0,0,16'h00C5, 0,1,1,16'hB301,0,0,1,0};
    tv[11] = '{0,0,16'hA201,16'hB301,1,0,16'h3C3C, 0,0,0,16'hB301,0,1,1,0};
    tv[12] = '{0,0,16'hA201,16'hB301,0,0,16'h3C3C, 0,0,0,16'hB301,0,0,1,1};

    sb_q.push_back('{owner: 1'b0, cmd: 16'hA201});
    sb_q.push_back('{owner: 1'b1, cmd: 16'hB301});

    for (int i = 0; i < 13; i++) begin
      tick();
      bus.req0      = tv[i].req0;
      bus.req1      = tv[i].req1;
      bus.cmd0      = tv[i].cmd0;
      bus.cmd1      = tv[i].cmd1;
      bus.m_done    = tv[i].m_done;
      bus.m_SS_n    = tv[i].m_ss_n;
      bus.m_rd_data = tv[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'({bus.gnt0, bus.gnt1}), 32'({tv[i].gnt0, tv[i].gnt1}));
      chk($sformatf("v%0d_wrt", i), 32'(bus.m_wrt), 32'(tv[i].wrt));
      chk($sformatf("v%0d_cmd", i), 32'(bus.m_cmd), 32'(tv[i].cmd));
      chk($sformatf("v%0d_done", i), 32'({bus.done0, bus.done1}), 32'({tv[i].done0, tv[i].done1}));
      chk($sformatf("v%0d_ss", i), 32'({bus.SS0_n, bus.SS1_n}), 32'({tv[i].ss0_n, tv[i].ss1_n}));
      chk($sformatf("v%0d_rd", i), 32'({bus.rd_data0, bus.rd_data1}), {tv[i].rd, tv[i].rd});
      $display("vector %0d applied", i);
    end

    // Reset in the middle of a transaction.
    bus.m_done = 1'b0;
    bus.m_SS_n = 1'b1;
    repeat (6) tick();
    sb_q.push_back('{owner: 1'b0, cmd: 16'h5A5A});
    bus.cmd0 = 16'h5A5A;
    bus.req0 = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (bus.m_wrt) got = 1'b1;
    end
    chk("rstx_launch_seen", 32'(got), 32'd1);
    tick();
    bus.req0 = 1'b0;
    bus.m_SS_n = 1'b0;
    tick();
    rst = 1'b1;
    bus.m_done = 1'b1;
    #1;
    chk("rstx_cmd", 32'(bus.m_cmd), 32'h0000);
    chk("rstx_wrt_gnt", 32'({bus.m_wrt, bus.gnt0, bus.gnt1}), 32'd0);
    chk("rstx_done", 32'({bus.done0, bus.done1}), 32'd0);
    chk("rstx_ss", 32'({bus.SS0_n, bus.SS1_n}), 32'b11);
    $display("mid-transaction reset checked");

    // Contention from reset: both requesters held, owners must alternate.
    tick();
    rst = 1'b0;
    bus.m_done = 1'b0;
    bus.m_SS_n = 1'b1;
    bus.cmd0 = 16'hA210;
    bus.cmd1 = 16'hC120;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    cyc_done = 0;
    for (int t = 0; t < 4; t++) begin
      own = t[0];
      sb_q.push_back('{owner: own, cmd: own ? 16'hC120 : 16'hA210});
      got = 1'b0;
      for (int w = 0; w < 30 && !got; w++) begin
        @(negedge clk);
        if (bus.m_wrt) got = 1'b1;
      end
      chk($sformatf("c%0d_launch_seen", t), 32'(got), 32'd1);
      cyc_wrt = cyc;
      if (t > 0) chk($sformatf("c%0d_gap_spacing", t), 32'(cyc_wrt - cyc_done), 32'(TB_GAP + 2));
      // Monarch model: 40 cycles of busy with SS_n low in the middle.
      for (int j = 0; j < 40; j++) begin
        tick();
        bus.m_SS_n = (j >= 2 && j < 38) ? 1'b0 : 1'b1;
        if (j == 20) begin
          @(negedge clk);
          chk($sformatf("c%0d_ss", t), 32'({bus.SS0_n, bus.SS1_n}), own ? 32'b10 : 32'b01);
          chk($sformatf("c%0d_nodone", t), 32'({bus.done0, bus.done1}), 32'd0);
        end
      end
      tick();
      bus.m_SS_n = 1'b1;
      bus.m_done = 1'b1;
      bus.m_rd_data = 16'h00C5 + 16'(t);
      @(negedge clk);
      chk($sformatf("c%0d_done", t), 32'({bus.done0, bus.done1}), own ? 32'b01 : 32'b10);
      chk($sformatf("c%0d_rd", t), 32'(own ? bus.rd_data1 : bus.rd_data0), 32'(16'h00C5 + 16'(t)));
      cyc_done = cyc;
      $display("transaction %0d owner=%0d done at cycle %0d", t, own, cyc_done);
      tick();
      bus.m_done = 1'b0;
      if (t == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end

    repeat (TB_GAP + 4) tick();
    @(negedge clk);
    chk("end_ss_idle", 32'({bus.SS0_n, bus.SS1_n}), 32'b11);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
